// File: rtl/flash_spi_pkg.sv
`default_nettype none
// ============================================================================
// flash_spi_pkg - state encoding and SPI-flash READ frame constants. Rev 1.0
// ============================================================================
package flash_spi_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_SHIFT = 2'd1,
    ST_DONE  = 2'd2,
    ST_GAP   = 2'd3
  } state_e;

  localparam logic [7:0] READ_CMD = 8'h03;
  localparam int CMD_BITS   = 8;
  localparam int ADDR_BITS  = 24;
  localparam int DATA_BITS  = 32;
  localparam int FRAME_BITS = 64;

endpackage
`default_nettype wire

// File: rtl/spi_edge_gen.sv
`default_nettype none
// ============================================================================
// spi_edge_gen - mode-0 SCK divider with one-cycle rise/fall strobes. Rev 1.0
// ============================================================================
module spi_edge_gen #(
  parameter int CLK_DIV = 2
) (
  input  logic clk,
  input  logic rst_n,
  input  logic en,
  output logic sck,
  output logic rise,
  output logic fall
);

  localparam int CNT_W = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
  localparam logic [CNT_W-1:0] LAST = CNT_W'(CLK_DIV - 1);

  logic [CNT_W-1:0] cnt_d, cnt_q;
  logic             sck_d, sck_q;
  logic             tick;

  // Strobes mark the cycle before sck toggles, so the consumer acts on the same edge.
  assign tick = en && (cnt_q == LAST);
  assign rise = tick && !sck_q;
  assign fall = tick && sck_q;
  assign sck  = sck_q;

  always_comb begin
    cnt_d = cnt_q;
    sck_d = sck_q;
    if (!en) begin
      cnt_d = '0;
      sck_d = 1'b0;
    end else if (tick) begin
      cnt_d = '0;
      sck_d = !sck_q;
    end else begin
      cnt_d = cnt_q + 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q <= '0;
      sck_q <= 1'b0;
    end else begin
      cnt_q <= cnt_d;
      sck_q <= sck_d;
    end
  end

endmodule
`default_nettype wire

// File: rtl/flash_spi_responder.sv
`default_nettype none
// ============================================================================
// flash_spi_responder - Avalon-MM word reads served by SPI-flash READ frames. Rev 1.0
// ============================================================================
module flash_spi_responder
  import flash_spi_pkg::*;
#(
  parameter int ADDR_W  = 22,
  parameter int CLK_DIV = 2,
  parameter int CS_GAP  = 4
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              flash_mem_read,
  input  logic [ADDR_W-1:0] flash_mem_address,
  output logic              flash_mem_waitrequest,
  output logic [31:0]       flash_mem_readdata,
  output logic              flash_mem_readdatavalid,
  output logic              spi_sck,
  output logic              spi_cs_n,
  output logic              spi_mosi,
  input  logic              spi_miso
);

  localparam int BIT_W = $clog2(FRAME_BITS);
  localparam int GAP_W = $clog2(CS_GAP + 1);
  localparam int TX_W  = CMD_BITS + ADDR_BITS;
  localparam logic [GAP_W-1:0] GAP_LAST = GAP_W'((CS_GAP > 1) ? CS_GAP - 2 : 0);

  state_e                 state_d, state_q;
  logic [BIT_W-1:0]       bit_d, bit_q;
  logic [GAP_W-1:0]       gap_d, gap_q;
  logic [TX_W-1:0]        tx_d, tx_q;
  logic [DATA_BITS-1:0]   rx_d, rx_q;
  logic                   wait_d, wait_q;
  logic                   cs_n_d, cs_n_q;
  logic                   mosi_d, mosi_q;
  logic                   rdv_d, rdv_q;
  logic [31:0]            rdata_d, rdata_q;
  logic [ADDR_BITS-1:0]   byte_addr;
  logic                   sck_rise, sck_fall;

  assign byte_addr = ADDR_BITS'({flash_mem_address, 2'b00});

  spi_edge_gen #(.CLK_DIV(CLK_DIV)) u_edge (
    .clk  (clk),
    .rst_n(rst_n),
    .en   (state_q == ST_SHIFT),
    .sck  (spi_sck),
    .rise (sck_rise),
    .fall (sck_fall)
  );

  always_comb begin
    state_d = state_q;
    bit_d   = bit_q;
    gap_d   = gap_q;
    tx_d    = tx_q;
    rx_d    = rx_q;
    wait_d  = wait_q;
    cs_n_d  = cs_n_q;
    mosi_d  = mosi_q;
    rdv_d   = 1'b0;
    rdata_d = rdata_q;
    case (state_q)
      ST_IDLE: begin
        wait_d = 1'b0;
        cs_n_d = 1'b1;
        mosi_d = 1'b0;
        bit_d  = '0;
        gap_d  = '0;
        if (flash_mem_read) begin
          state_d = ST_SHIFT;
          wait_d  = 1'b1;
          cs_n_d  = 1'b0;
          mosi_d  = READ_CMD[7];
          tx_d    = {READ_CMD[6:0], byte_addr, 1'b0};
        end
      end
      ST_SHIFT: begin
        if (sck_rise && (bit_q >= BIT_W'(TX_W)))
          rx_d = {rx_q[DATA_BITS-2:0], spi_miso};
        if (sck_fall) begin
          if (bit_q == BIT_W'(FRAME_BITS - 1)) begin
            state_d = ST_DONE;
            cs_n_d  = 1'b1;
            mosi_d  = 1'b0;
            rdv_d   = 1'b1;
            // First byte on the wire lands in the least significant lane.
            rdata_d = {rx_q[7:0], rx_q[15:8], rx_q[23:16], rx_q[31:24]};
          end else begin
            bit_d  = bit_q + 1'b1;
            mosi_d = tx_q[TX_W-1];
            tx_d   = {tx_q[TX_W-2:0], 1'b0};
          end
        end
      end
      ST_DONE: begin
        gap_d = '0;
        if (CS_GAP > 1) begin
          state_d = ST_GAP;
        end else begin
          state_d = ST_IDLE;
          wait_d  = 1'b0;
        end
      end
      default: begin
        if (gap_q == GAP_LAST) begin
          state_d = ST_IDLE;
          wait_d  = 1'b0;
        end else begin
          gap_d = gap_q + 1'b1;
        end
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= ST_IDLE;
      bit_q   <= '0;
      gap_q   <= '0;
      tx_q    <= '0;
      rx_q    <= '0;
      wait_q  <= 1'b0;
      cs_n_q  <= 1'b1;
      mosi_q  <= 1'b0;
      rdv_q   <= 1'b0;
      rdata_q <= '0;
    end else begin
      state_q <= state_d;
      bit_q   <= bit_d;
      gap_q   <= gap_d;
      tx_q    <= tx_d;
      rx_q    <= rx_d;
      wait_q  <= wait_d;
      cs_n_q  <= cs_n_d;
      mosi_q  <= mosi_d;
      rdv_q   <= rdv_d;
      rdata_q <= rdata_d;
    end
  end

  assign flash_mem_waitrequest   = wait_q;
  assign flash_mem_readdata      = rdata_q;
  assign flash_mem_readdatavalid = rdv_q;
  assign spi_cs_n                = cs_n_q;
  assign spi_mosi                = mosi_q;

endmodule
`default_nettype wire

// File: tb/tb_flash_spi_responder.sv
`default_nettype none
// ============================================================================
// tb_flash_spi_responder - scoreboard bench with a behavioural SPI flash. Rev 1.0
// ============================================================================
module tb_flash_spi_responder;

  localparam int ADDR_W = 22;
  localparam int CS_GAP = 4;

  typedef struct {
    int          bitcnt;
    logic        prev;
    logic [31:0] cap;
    logic [31:0] frame;
    logic        miso;
    int          mosi_err;
    int          frames;
  } model_t;

  typedef struct {
    logic [31:0] word;
    int          cyc;
  } exp_t;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic rd0 = 1'b0, rd1 = 1'b0;
  logic [ADDR_W-1:0] ad0 = '0, ad1 = '0;
  logic wr0, rdv0, sck0, cs0, mosi0, miso0;
  logic wr1, rdv1, sck1, cs1, mosi1, miso1;
  logic [31:0] rdat0, rdat1;

  model_t m0 = '{0, 1'b0, 32'h0, 32'h0, 1'b0, 0, 0};
  model_t m1 = '{0, 1'b0, 32'h0, 32'h0, 1'b0, 0, 0};
  exp_t q0[$];
  exp_t q1[$];
  exp_t e0, e1;
  int cyc = 0;
  int asserts = 0;
  int fails = 0;
  int gap_run0 = 0;
  int last_gap0 = 0;

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  flash_spi_responder #(.ADDR_W(ADDR_W), .CLK_DIV(2), .CS_GAP(CS_GAP)) dut (
    .clk(clk), .rst_n(rst_n),
    .flash_mem_read(rd0), .flash_mem_address(ad0),
    .flash_mem_waitrequest(wr0), .flash_mem_readdata(rdat0),
    .flash_mem_readdatavalid(rdv0),
    .spi_sck(sck0), .spi_cs_n(cs0), .spi_mosi(mosi0), .spi_miso(miso0)
  );

  flash_spi_responder #(.ADDR_W(ADDR_W), .CLK_DIV(1), .CS_GAP(CS_GAP)) dut_div1 (
    .clk(clk), .rst_n(rst_n),
    .flash_mem_read(rd1), .flash_mem_address(ad1),
    .flash_mem_waitrequest(wr1), .flash_mem_readdata(rdat1),
    .flash_mem_readdatavalid(rdv1),
    .spi_sck(sck1), .spi_cs_n(cs1), .spi_mosi(mosi1), .spi_miso(miso1)
  );

  function automatic logic [7:0] byte_of(input logic [23:0] a);
    case (a)
      24'h000004: return 8'h11;
      24'h000005: return 8'h22;
      24'h000006: return 8'h33;
      24'h000007: return 8'h44;
      default:    return 8'(a[7:0] * 8'd7) ^ a[15:8] ^ a[23:16] ^ 8'h5A;
    endcase
  endfunction

  function automatic logic [31:0] exp_word(input logic [ADDR_W-1:0] w);
    logic [23:0] b;
    b = {w, 2'b00};
    return {byte_of(b + 24'd3), byte_of(b + 24'd2), byte_of(b + 24'd1), byte_of(b)};
  endfunction

  // Serial flash: capture cmd+addr on rising SCK, drive data on falling SCK.
  function automatic model_t model_next(input model_t m, input logic sck,
                                        input logic cs_n, input logic mosi);
    model_t n = m;
    int j;
    logic [7:0] b;
    if (cs_n !== 1'b0) begin
      n.bitcnt = 0;
      n.miso = 1'b0;
    end else if (sck === 1'b1 && m.prev !== 1'b1) begin
      if (n.bitcnt < 32) n.cap = {n.cap[30:0], mosi};
      else if (mosi !== 1'b0) n.mosi_err++;
      n.bitcnt++;
      if (n.bitcnt == 32) begin
        n.frame = n.cap;
        n.frames++;
      end
    end else if (sck === 1'b0 && m.prev === 1'b1) begin
      if (n.bitcnt >= 32 && n.bitcnt < 64) begin
        j = n.bitcnt - 32;
        b = byte_of(n.frame[23:0] + 24'(j / 8));
        n.miso = b[7 - (j % 8)];
      end
    end
    n.prev = sck;
    return n;
  endfunction

  always @(sck0 or cs0) m0 = model_next(m0, sck0, cs0, mosi0);
  always @(sck1 or cs1) m1 = model_next(m1, sck1, cs1, mosi1);
  assign miso0 = m0.miso;
  assign miso1 = m1.miso;

  // Output side of the scoreboard plus cs_n-high run length for dut.
  always @(negedge clk) begin
    if (rdv0 === 1'b1) begin
      asserts++;
      if (q0.size() == 0) begin
        fails++;
        $display("FAIL rdv0_unexpected: pulse at cycle %0d, none outstanding", cyc);
      end else begin
        e0 = q0.pop_front();
        if (rdat0 !== e0.word || cyc != e0.cyc) begin
          fails++;
          $display("FAIL rdv0_word: got %h at cycle %0d, expected %h at cycle %0d",
                   rdat0, cyc, e0.word, e0.cyc);
        end
      end
    end
    if (rdv1 === 1'b1) begin
      asserts++;
      if (q1.size() == 0) begin
        fails++;
        $display("FAIL rdv1_unexpected: pulse at cycle %0d, none outstanding", cyc);
      end else begin
        e1 = q1.pop_front();
        if (rdat1 !== e1.word || cyc != e1.cyc) begin
          fails++;
          $display("FAIL rdv1_word: got %h at cycle %0d, expected %h at cycle %0d",
                   rdat1, cyc, e1.word, e1.cyc);
        end
      end
    end
    if (cs0 === 1'b1) gap_run0++;
    else if (gap_run0 > 0) begin
      last_gap0 = gap_run0;
      gap_run0 = 0;
    end
  end

  // Presents a read at a negedge and waits (bounded) for the accepting cycle.
  task automatic req(input int which, input logic [ADDR_W-1:0] a, output int t0);
    t0 = -1;
    if (which == 0) begin rd0 = 1'b1; ad0 = a; end
    else begin rd1 = 1'b1; ad1 = a; end
    for (int i = 0; i < 2000; i++) begin
      if ((which == 0 ? wr0 : wr1) === 1'b0) begin
        t0 = cyc;
        break;
      end
      @(negedge clk);
    end
    asserts++;
    if (t0 < 0) begin
      fails++;
      $display("FAIL accept%0d: read never accepted, required within 2000 cycles", which);
    end else begin
      if (which == 0) q0.push_back('{word: exp_word(a), cyc: t0 + 1 + 128 * 2});
      else q1.push_back('{word: exp_word(a), cyc: t0 + 1 + 128 * 1});
    end
    @(negedge clk);
  endtask

  task automatic drain(input int which);
    int left;
    left = 0;
    for (int i = 0; i < 600; i++) begin
      left = (which == 0) ? q0.size() : q1.size();
      if (left == 0) break;
      @(negedge clk);
    end
    asserts++;
    if (left != 0) begin
      fails++;
      $display("FAIL drain%0d: %0d words outstanding, required 0", which, left);
    end
  endtask

  task automatic test_reset();
    for (int i = 0; i < 6; i++) begin
      @(negedge clk);
      rd0 = i[0];
      ad0 = ADDR_W'($urandom);
      asserts++;
      if ({wr0, rdv0, rdat0, sck0, cs0, mosi0} !== {1'b0, 1'b0, 32'h0, 1'b0, 1'b1, 1'b0}) begin
        fails++;
        $display("FAIL reset_outputs: wr=%b rdv=%b rd=%h sck=%b cs_n=%b mosi=%b, required 0 0 0 0 1 0",
                 wr0, rdv0, rdat0, sck0, cs0, mosi0);
      end
    end
    rd0 = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    repeat (2) @(negedge clk);
  endtask

  task automatic test_single();
    int t0, tw;
    req(0, 22'h000001, t0);
    rd0 = 1'b0;
    tw = -1;
    for (int i = 0; i < 400; i++) begin
      if (wr0 === 1'b0) begin tw = cyc; break; end
      @(negedge clk);
    end
    asserts++;
    if (tw != t0 + 261) begin
      fails++;
      $display("FAIL single_wait_low: waitrequest low at cycle %0d, required %0d", tw, t0 + 261);
    end
    asserts++;
    if (m0.frame !== 32'h03000004) begin
      fails++;
      $display("FAIL single_frame: mosi carried %h, required 03000004", m0.frame);
    end
    drain(0);
    repeat (10) @(negedge clk);
    asserts++;
    if (rdat0 !== 32'h44332211) begin
      fails++;
      $display("FAIL single_hold: readdata %h, required 44332211", rdat0);
    end
  endtask

  task automatic test_back_to_back();
    int t0, t1, f;
    f = m0.frames;
    req(0, 22'h000010, t0);
    req(0, 22'h000011, t1);
    rd0 = 1'b0;
    asserts++;
    if (t1 != t0 + 261) begin
      fails++;
      $display("FAIL b2b_accept: second accepted at cycle %0d, required %0d", t1, t0 + 261);
    end
    drain(0);
    asserts++;
    if (last_gap0 < CS_GAP) begin
      fails++;
      $display("FAIL b2b_cs_gap: cs_n high %0d cycles, required at least %0d", last_gap0, CS_GAP);
    end
    asserts++;
    if (m0.frames != f + 2 || m0.frame !== 32'h03000044) begin
      fails++;
      $display("FAIL b2b_frames: %0d frames last %h, required 2 frames last 03000044",
               m0.frames - f, m0.frame);
    end
  endtask

  task automatic test_max_addr();
    int t0;
    req(0, 22'h3FFFFF, t0);
    rd0 = 1'b0;
    drain(0);
    asserts++;
    if (m0.frame !== 32'h03FFFFFC) begin
      fails++;
      $display("FAIL max_addr_frame: mosi carried %h, required 03FFFFFC", m0.frame);
    end
  endtask

  task automatic test_reset_mid();
    int t0;
    req(0, 22'h000005, t0);
    rd0 = 1'b0;
    for (int i = 0; i < 300 && cyc < t0 + 150; i++) @(negedge clk);
    asserts++;
    if (cs0 !== 1'b0 || cyc != t0 + 150) begin
      fails++;
      $display("FAIL midrst_active: cs_n=%b at cycle %0d, required 0 at %0d", cs0, cyc, t0 + 150);
    end
    #2 rst_n = 1'b0;
    #1;
    asserts++;
    if (cs0 !== 1'b1 || sck0 !== 1'b0 || rdv0 !== 1'b0) begin
      fails++;
      $display("FAIL midrst_async: cs_n=%b sck=%b rdv=%b, required 1 0 0", cs0, sck0, rdv0);
    end
    q0.delete();
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    repeat (300) @(negedge clk);
    asserts++;
    if (wr0 !== 1'b0 || cs0 !== 1'b1) begin
      fails++;
      $display("FAIL midrst_idle: wr=%b cs_n=%b, required 0 1", wr0, cs0);
    end
    req(0, 22'h000002, t0);
    rd0 = 1'b0;
    drain(0);
    asserts++;
    if (m0.frame !== 32'h03000008) begin
      fails++;
      $display("FAIL midrst_frame: mosi carried %h, required 03000008", m0.frame);
    end
  endtask

  task automatic test_clk_div1();
    int t0, r0, r1;
    logic prev;
    req(1, 22'h0ABCDE, t0);
    rd1 = 1'b0;
    r0 = -1;
    r1 = -1;
    prev = sck1;
    for (int i = 0; i < 100 && r1 < 0; i++) begin
      @(negedge clk);
      if (sck1 === 1'b1 && prev === 1'b0) begin
        if (r0 < 0) r0 = cyc;
        else r1 = cyc;
      end
      prev = sck1;
    end
    asserts++;
    if (r1 - r0 != 2 || r0 < 0) begin
      fails++;
      $display("FAIL div1_period: sck period %0d cycles, required 2", r1 - r0);
    end
    drain(1);
    asserts++;
    if (m1.frame !== 32'h032AF378 || m1.mosi_err != 0) begin
      fails++;
      $display("FAIL div1_frame: mosi carried %h (%0d data-phase errors), required 032AF378 and 0",
               m1.frame, m1.mosi_err);
    end
  endtask

  initial begin
    test_reset();
    test_single();
    test_back_to_back();
    test_max_addr();
    test_reset_mid();
    test_clk_div1();
    asserts++;
    if (m0.mosi_err != 0) begin
      fails++;
      $display("FAIL mosi_data_phase: %0d nonzero mosi bits during data, required 0", m0.mosi_err);
    end
    $display("End of test - %0d assertions evaluated, %0d failures", asserts, fails);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/flash_spi_responder.md
Name: flash_spi_responder

Overview:
- Avalon-MM read-only responder that serves word reads from the flash reader side of the design.
- Each accepted read becomes one SPI-flash READ (0x03) transaction: 8-bit command, 24-bit byte address, 32 data bits.
- The four bytes returned on the wire are assembled into one 32-bit word and presented with a single-cycle flash_mem_readdatavalid pulse.
- Sits between the flash reader logic and the external serial flash pins.

Parameters:
ADDR_W, 22, word-address width; must be <= 22 so the byte address fits in 24 bits
CLK_DIV, 2, SCK half-period in clk cycles; must be >= 1
CS_GAP, 4, minimum clk cycles cs_n stays high between transactions; must be >= 1

Ports:
clk  input  1  system clock, single clock domain
rst_n  input  1  asynchronous, active-low reset
flash_mem_read  input  1  read request, held by the master until accepted
flash_mem_address  input  ADDR_W  32-bit word address
flash_mem_waitrequest  output  1  high = request not accepted
flash_mem_readdata  output  32  returned word
flash_mem_readdatavalid  output  1  one-cycle pulse qualifying readdata
spi_sck  output  1  SPI clock, mode 0
spi_cs_n  output  1  flash chip select, active low
spi_mosi  output  1  command and address bits
spi_miso  input  1  data from flash

Behaviour:
- Reset values: waitrequest 0, readdatavalid 0, readdata 0, sck 0, cs_n 1, mosi 0, FSM IDLE, all counters 0.
- Reset is asynchronous. Asserting rst_n mid-transaction forces outputs to reset values immediately: cs_n 1, sck 0, no readdatavalid, transaction discarded.
- FSM states: IDLE -> SHIFT -> DONE -> GAP -> IDLE.
- IDLE: waitrequest = 0. A read is accepted at edge T0 when read && !waitrequest; address is latched at that edge. Go to SHIFT.
- Byte address on the wire = {flash_mem_address, 2'b00}, zero-extended to 24 bits.
- SHIFT: cs_n 0 from T0+1, waitrequest 1.
  - Frame is 64 bits: 0x03, then the 24-bit address, then 32 read bits, MSB first per byte.
  - mosi is valid from T0+1 for bit 0 and changes only on SCK falling edges (mode 0).
  - sck rises CLK_DIV cycles after each bit is presented and falls CLK_DIV cycles later.
  - miso is sampled on each SCK rising edge during bits 32..63 only. mosi is 0 during those bits.
  - After the 64th falling edge go to DONE.
- Byte order: wire byte k (k = 0..3, first received = 0) goes to readdata[8k+7:8k], i.e. little-endian.
- DONE: a single cycle at T0+1+128*CLK_DIV.
  - readdatavalid 1, readdata updated, cs_n 1, sck 0.
  - readdata holds its value until the next DONE.
- GAP: cs_n 1, waitrequest 1 for CS_GAP cycles. waitrequest drops to 0 at T0+1+128*CLK_DIV+CS_GAP.
- Busy handling: read asserted while waitrequest = 1 is ignored, not queued. The master holds the request and it is accepted on the first cycle waitrequest is low. At most one transaction is outstanding.
- sck is 0 whenever cs_n = 1; there are no stray edges.
- One bit counter (0..63) and one divide counter (0..CLK_DIV-1); both clear in IDLE.

Decomposition:
- Package flash_spi_pkg holds:
  - the state enum;
  - READ_CMD = 8'h03;
  - CMD_BITS = 8, ADDR_BITS = 24, DATA_BITS = 32, FRAME_BITS = 64.
- Sub-module spi_edge_gen is natural: a divide counter producing sck plus one-cycle rise/fall strobes, enabled only in SHIFT.
- The FSM, shift registers and byte assembly stay in flash_spi_responder.

Test Plan:
Bench setup: CLK_DIV=2, CS_GAP=4, behavioural SPI flash model.
1. Reset: hold rst_n low, toggle inputs -> waitrequest 0, readdatavalid 0, readdata 0, sck 0, cs_n 1, mosi 0 throughout.
2. Single read: address 0x000001, model bytes 0x4..0x7 = 0x11, 0x22, 0x33, 0x44.
   - mosi carries 0x03 then 0x000004.
   - readdatavalid pulses once at T0+257 with readdata 0x44332211.
   - waitrequest low at T0+261.
3. Back-to-back: read held high for addresses 0x10 then 0x11.
   - Second request accepted exactly at T0+261.
   - cs_n high for 4 cycles between frames.
   - Exactly two readdatavalid pulses with the correct words.
4. Max address 0x3FFFFF -> wire address 0xFFFFFC; data from bytes 0xFFFFFC..0xFFFFFF returned correctly.
5. Reset mid-data at T0+150:
   - cs_n rises and sck drops within the same cycle, asynchronously.
   - No readdatavalid.
   - After release, a new read to 0x2 completes normally.
6. CLK_DIV=1: readdatavalid at T0+129; sck period is 2 cycles; data matches the model.
